// File: rtl/phase_acc_pkg.sv
// rtl/phase_acc_pkg.sv - shared types and helpers for the multi-channel phase accumulator
package phase_acc_pkg;

  localparam int BEAT_PHASE_W = 64;
  localparam int BEAT_DEST_W  = 16;

  function automatic int ch_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Fields are sized for the widest supported build; instances use the low bits.
  typedef struct packed {
    logic [BEAT_PHASE_W-1:0] phase;
    logic [BEAT_DEST_W-1:0]  dest;
    logic                    wrap;
    logic                    last;
  } beat_t;

endpackage

// File: rtl/multi_phase_accumulator_if.sv
// rtl/multi_phase_accumulator_if.sv - phase load, step write and phase sample streams
interface multi_phase_accumulator_if
  import phase_acc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int CH_W = ch_width(CHANNELS);

  logic [WIDTH-1:0] input_phase_tdata;
  logic [CH_W-1:0]  input_phase_tdest;
  logic             input_phase_tvalid;
  logic             input_phase_tready;
  logic [WIDTH-1:0] input_phase_step_tdata;
  logic [CH_W-1:0]  input_phase_step_tdest;
  logic             input_phase_step_tvalid;
  logic             input_phase_step_tready;
  logic [WIDTH-1:0] output_phase_tdata;
  logic [CH_W-1:0]  output_phase_tdest;
  logic             output_phase_tuser;
  logic             output_phase_tlast;
  logic             output_phase_tvalid;
  logic             output_phase_tready;

  modport master (
    output input_phase_tdata, input_phase_tdest, input_phase_tvalid,
    input  input_phase_tready,
    output input_phase_step_tdata, input_phase_step_tdest, input_phase_step_tvalid,
    input  input_phase_step_tready,
    input  output_phase_tdata, output_phase_tdest, output_phase_tuser,
    input  output_phase_tlast, output_phase_tvalid,
    output output_phase_tready
  );

  modport slave (
    input  input_phase_tdata, input_phase_tdest, input_phase_tvalid,
    output input_phase_tready,
    input  input_phase_step_tdata, input_phase_step_tdest, input_phase_step_tvalid,
    output input_phase_step_tready,
    output output_phase_tdata, output_phase_tdest, output_phase_tuser,
    output output_phase_tlast, output_phase_tvalid,
    input  output_phase_tready
  );

endinterface

// File: rtl/phase_acc_regfile.sv
// rtl/phase_acc_regfile.sv - per-channel phase, step and wrap storage
module phase_acc_regfile
  import phase_acc_pkg::*;
#(
  parameter int               WIDTH              = 32,
  parameter int               CHANNELS           = 4,
  parameter logic [WIDTH-1:0] INITIAL_PHASE_STEP = '0,
  localparam int              CH_W               = ch_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH_W-1:0]  rd_ptr,
  output logic [WIDTH-1:0] rd_phase,
  output logic [WIDTH-1:0] rd_step,
  output logic             rd_wrap,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] acc_phase,
  input  logic             acc_wrap,
  input  logic             ld_en,
  input  logic [CH_W-1:0]  ld_dest,
  input  logic [WIDTH-1:0] ld_phase,
  input  logic             st_en,
  input  logic [CH_W-1:0]  st_dest,
  input  logic [WIDTH-1:0] st_step
);

  logic [WIDTH-1:0]    phase_q [CHANNELS];
  logic [WIDTH-1:0]    step_q  [CHANNELS];
  logic [CHANNELS-1:0] wrap_q;

  always_comb begin
    rd_phase = '0;
    rd_step  = '0;
    rd_wrap  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ptr == CH_W'(i)) begin
        rd_phase = phase_q[i];
        rd_step  = step_q[i];
        rd_wrap  = wrap_q[i];
      end
    end
  end

  // Destinations beyond CHANNELS-1 match no entry, so they are dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
        step_q[i]  <= INITIAL_PHASE_STEP;
      end
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ld_en && ld_dest == CH_W'(i)) begin
          phase_q[i] <= ld_phase;
          wrap_q[i]  <= 1'b0;
        end else if (acc_en && rd_ptr == CH_W'(i)) begin
          phase_q[i] <= acc_phase;
          wrap_q[i]  <= acc_wrap;
        end
        if (st_en && st_dest == CH_W'(i)) begin
          step_q[i] <= st_step;
        end
      end
    end
  end

endmodule

// File: rtl/multi_phase_accumulator.sv
// rtl/multi_phase_accumulator.sv - round-robin multi-channel phase accumulator with registered stream output
module multi_phase_accumulator
  import phase_acc_pkg::*;
#(
  parameter int               WIDTH              = 32,
  parameter int               CHANNELS           = 4,
  parameter logic [WIDTH-1:0] INITIAL_PHASE_STEP = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  multi_phase_accumulator_if.slave bus
);

  localparam int              CH_W    = ch_width(CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  logic [CH_W-1:0]  ptr;
  logic [WIDTH-1:0] cur_phase;
  logic [WIDTH-1:0] cur_step;
  logic [WIDTH-1:0] sum;
  logic             cur_wrap;
  logic             carry;
  logic             adv;
  beat_t            beat_q;
  logic             tvalid_q;
  logic             unused_beat;

  assign adv          = !tvalid_q || bus.output_phase_tready;
  assign {carry, sum} = {1'b0, cur_phase} + {1'b0, cur_step};

  phase_acc_regfile #(
    .WIDTH              (WIDTH),
    .CHANNELS           (CHANNELS),
    .INITIAL_PHASE_STEP (INITIAL_PHASE_STEP)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_ptr    (ptr),
    .rd_phase  (cur_phase),
    .rd_step   (cur_step),
    .rd_wrap   (cur_wrap),
    .acc_en    (adv),
    .acc_phase (sum),
    .acc_wrap  (carry),
    .ld_en     (bus.input_phase_tvalid),
    .ld_dest   (bus.input_phase_tdest),
    .ld_phase  (bus.input_phase_tdata),
    .st_en     (bus.input_phase_step_tvalid),
    .st_dest   (bus.input_phase_step_tdest),
    .st_step   (bus.input_phase_step_tdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
    end else if (adv) begin
      beat_q.phase <= BEAT_PHASE_W'(cur_phase);
      beat_q.dest  <= BEAT_DEST_W'(ptr);
      beat_q.wrap  <= cur_wrap;
      beat_q.last  <= (ptr == LAST_CH);
      tvalid_q     <= 1'b1;
      ptr          <= (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
    end
  end

  assign bus.input_phase_tready      = 1'b1;
  assign bus.input_phase_step_tready = 1'b1;
  assign bus.output_phase_tdata      = beat_q.phase[WIDTH-1:0];
  assign bus.output_phase_tdest      = beat_q.dest[CH_W-1:0];
  assign bus.output_phase_tuser      = beat_q.wrap;
  assign bus.output_phase_tlast      = beat_q.last;
  assign bus.output_phase_tvalid     = tvalid_q;
  assign unused_beat                 = ^beat_q;

endmodule

// File: tb/tb_multi_phase_accumulator.sv
// tb/tb_multi_phase_accumulator.sv - randomized model-checked bench for multi_phase_accumulator
module tb_multi_phase_accumulator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ph_v = 1'b0, st_v = 1'b0, rdy = 1'b1;
  logic [1:0] ph_d = '0, st_d = '0;
  logic [7:0] ph_x = '0, st_x = '0;

  always #5 clk = ~clk;

  multi_phase_accumulator_if #(.WIDTH(W), .CHANNELS(4)) ia ();
  multi_phase_accumulator_if #(.WIDTH(W), .CHANNELS(3)) ib ();

  assign ia.input_phase_tdata       = ph_x;
  assign ia.input_phase_tdest       = ph_d;
  assign ia.input_phase_tvalid      = ph_v;
  assign ia.input_phase_step_tdata  = st_x;
  assign ia.input_phase_step_tdest  = st_d;
  assign ia.input_phase_step_tvalid = st_v;
  assign ia.output_phase_tready     = rdy;
  assign ib.input_phase_tdata       = ph_x;
  assign ib.input_phase_tdest       = ph_d;
  assign ib.input_phase_tvalid      = ph_v;
  assign ib.input_phase_step_tdata  = st_x;
  assign ib.input_phase_step_tdest  = st_d;
  assign ib.input_phase_step_tvalid = st_v;
  assign ib.output_phase_tready     = rdy;

  multi_phase_accumulator #(.WIDTH(W), .CHANNELS(4), .INITIAL_PHASE_STEP(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  multi_phase_accumulator #(.WIDTH(W), .CHANNELS(3), .INITIAL_PHASE_STEP(8'h05)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int checks = 0;
  int errors = 0;

  // Reference state: d=0 is the 4-channel instance, d=1 the 3-channel one.
  int nch [2] = '{4, 3};
  int init_step [2] = '{0, 5};
  int m_phase [2][4];
  int m_step [2][4];
  int m_wrap [2][4];
  int m_ptr [2];
  int e_valid [2], e_data [2], e_dest [2], e_user [2], e_last [2];

  typedef struct {int data; int dest; int user; int last;} beat_s;
  beat_s log_q[$];
  bit    logging = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_phase[d][c] = 0;
        m_step[d][c]  = init_step[d];
        m_wrap[d][c]  = 0;
      end
      m_ptr[d] = 0;
      e_valid[d] = 0; e_data[d] = 0; e_dest[d] = 0; e_user[d] = 0; e_last[d] = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int p = m_ptr[d];
      int s;
      if (!e_valid[d] || rdy) begin
        if (d == 0 && logging && e_valid[0])
          log_q.push_back('{e_data[0], e_dest[0], e_user[0], e_last[0]});
        e_valid[d] = 1;
        e_data[d]  = m_phase[d][p];
        e_dest[d]  = p;
        e_user[d]  = m_wrap[d][p];
        e_last[d]  = (p == nch[d] - 1) ? 1 : 0;
        s = m_phase[d][p] + m_step[d][p];
        m_phase[d][p] = s % 256;
        m_wrap[d][p]  = (s >= 256) ? 1 : 0;
        m_ptr[d]      = (p + 1) % nch[d];
      end
      if (ph_v && int'(ph_d) < nch[d]) begin
        m_phase[d][ph_d] = int'(ph_x);
        m_wrap[d][ph_d]  = 0;
      end
      if (st_v && int'(st_d) < nch[d]) m_step[d][st_d] = int'(st_x);
    end
  endtask

  task automatic compare_all();
    chk("a_tvalid", ia.output_phase_tvalid, e_valid[0]);
    chk("a_tdata",  ia.output_phase_tdata,  e_data[0]);
    chk("a_tdest",  ia.output_phase_tdest,  e_dest[0]);
    chk("a_tuser",  ia.output_phase_tuser,  e_user[0]);
    chk("a_tlast",  ia.output_phase_tlast,  e_last[0]);
    chk("a_in_ready", {ia.input_phase_tready, ia.input_phase_step_tready}, 3);
    chk("b_tvalid", ib.output_phase_tvalid, e_valid[1]);
    chk("b_tdata",  ib.output_phase_tdata,  e_data[1]);
    chk("b_tdest",  ib.output_phase_tdest,  e_dest[1]);
    chk("b_tuser",  ib.output_phase_tuser,  e_user[1]);
    chk("b_tlast",  ib.output_phase_tlast,  e_last[1]);
    chk("b_in_ready", {ib.input_phase_tready, ib.input_phase_step_tready}, 3);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int k;
    int exp2 [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    model_reset();
    #1;
    compare_all();
    chk("reset_tvalid_lit", ia.output_phase_tvalid, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("first_tvalid_lit", ia.output_phase_tvalid, 1);
    chk("first_tdata_lit",  ia.output_phase_tdata, 0);
    chk("first_tdest_lit",  ia.output_phase_tdest, 0);
    chk("first_b_tdata_lit", ib.output_phase_tdata, 0);
    repeat (6) tick();

    st_v = 1'b1; st_d = 2'd2; st_x = 8'h40;
    tick();
    st_v = 1'b0;
    logging = 1;
    repeat (28) tick();
    logging = 0;
    k = 0;
    foreach (log_q[i]) begin
      if (i > 0) chk("seq_dest_order", log_q[i].dest, (log_q[i-1].dest + 1) % 4);
      chk("seq_tlast", log_q[i].last, (log_q[i].dest == 3) ? 1 : 0);
      if (log_q[i].dest == 2) begin
        if (k < 5) begin
          chk("ch2_data_lit", log_q[i].data, exp2[k]);
          chk("ch2_wrap_lit", log_q[i].user, (k == 4) ? 1 : 0);
        end
        k++;
      end else begin
        chk("other_ch_zero", log_q[i].data, 0);
      end
    end
    chk("ch2_beats", (k >= 5) ? 1 : 0, 1);

    for (int n = 0; n < 3000; n++) begin
      ph_v = ($urandom_range(0, 3) == 0);
      ph_d = 2'($urandom_range(0, 3));
      ph_x = 8'($urandom);
      st_v = ($urandom_range(0, 4) == 0);
      st_d = 2'($urandom_range(0, 3));
      st_x = 8'($urandom);
      rdy  = ($urandom_range(0, 3) != 0) && !((n % 200) > 0 && (n % 200) < 6);
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_tvalid_lit", ia.output_phase_tvalid, 0);
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
